instr_fetch: RTL and testbench

Instruction fetch stage of the control unit, directly upstream of the decoder. Walks a program counter through the synchronous instruction memory, buffers returned 18-bit words in a small prefetch FIFO, and presents them to the decoder over a valid/ready handshake. Handles loop-back redirects by flushing buffered and in-flight words, and stops at a HALT word.

---
 rtl/instr_fetch_pkg.sv | 20 ++
 rtl/fetch_fifo.sv | 62 ++++++
 rtl/instr_fetch.sv | 127 ++++++++++++
 tb/tb_instr_fetch.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared control-unit definitions: instruction/opcode widths, HALT opcode and fetch state enum.
package instr_fetch_pkg;

  localparam int unsigned OPC_W   = 5;
  localparam int unsigned INSTR_W = 18;

  localparam logic [OPC_W-1:0] OPC_HALT = 5'd31;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StHalted
  } fetch_state_e;

  function automatic logic is_halt(input logic [INSTR_W-1:0] word);
    return word[INSTR_W-1 -: OPC_W] == OPC_HALT;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO with flush; the head entry is presented directly from storage.
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 18
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic [PtrW:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (cnt != '0);
  // A pop in the same cycle frees the slot, so a push into a full FIFO is not lost.
  assign do_push = push && ((cnt != (PtrW + 1)'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        storage[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        storage[wr_ptr] <= push_data;
        wr_ptr          <= wr_ptr + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PtrW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (PtrW + 1)'(1);
        2'b01:   cnt <= cnt - (PtrW + 1)'(1);
        default: ;
      endcase
    end
  end

  assign head  = storage[rd_ptr];
  assign valid = (cnt != '0);
  assign count = cnt;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC walk, prefetch FIFO, redirect flush and HALT drain.
// Optional FETCH_PERF_EN adds saturating fetch_count / stall_count outputs.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W-1:0]  start_addr,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_addr,
  output logic               imem_rd_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] raw_instruction,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic               busy,
  output logic               halted
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        fetch_count,
  output logic [31:0]        stall_count
`endif
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e      state;
  logic [ADDR_W-1:0] pc;
  logic              inflight;
  logic              inflight_epoch;
  logic              epoch;
  logic [CntW-1:0]   fifo_count;

  logic start_go;
  logic redirect_go;
  logic ret_valid;
  logic ret_halt;
  logic fifo_push;
  logic fifo_pop;
  logic fifo_flush;

  assign start_go    = start && ((state == StIdle) || (state == StHalted));
  assign redirect_go = redirect && ((state == StRun) || (state == StDrain));

  // A return counts only if it was issued in the current epoch.
  assign ret_valid = inflight && (inflight_epoch == epoch);
  assign ret_halt  = ret_valid && is_halt(imem_rdata);

  assign imem_rd_en = (state == StRun) &&
                      (({1'b0, fifo_count} + {{CntW{1'b0}}, inflight}) < (CntW + 1)'(FIFO_DEPTH));
  assign imem_addr  = pc;

  assign fifo_pop   = instr_valid && instr_ready;
  assign fifo_flush = redirect_go || start_go;
  assign fifo_push  = ret_valid && !ret_halt && (state == StRun);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= StIdle;
      pc             <= '0;
      inflight       <= 1'b0;
      inflight_epoch <= 1'b0;
      epoch          <= 1'b0;
    end else begin
      inflight       <= imem_rd_en;
      inflight_epoch <= epoch;
      if (imem_rd_en) begin
        pc <= pc + ADDR_W'(1);
      end
      if (redirect_go) begin
        pc    <= redirect_addr;
        epoch <= ~epoch;
        state <= StRun;
      end else if (start_go) begin
        pc    <= start_addr;
        epoch <= ~epoch;
        state <= StRun;
      end else begin
        case (state)
          StRun:   if (ret_halt) state <= StDrain;
          StDrain: if (fifo_count == '0) state <= StHalted;
          default: ;
        endcase
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (INSTR_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .push_data (imem_rdata),
    .pop       (fifo_pop),
    .head      (raw_instruction),
    .valid     (instr_valid),
    .count     (fifo_count)
  );

  assign busy   = (state == StRun) || (state == StDrain);
  assign halted = (state == StHalted);

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (reset || start_go) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (fifo_pop && (fetch_count != '1)) begin
        fetch_count <= fetch_count + 32'd1;
      end
      if (instr_valid && !instr_ready && (stall_count != '1)) begin
        stall_count <= stall_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch with a synchronous instruction memory model.
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  localparam int unsigned AW    = 10;
  localparam int unsigned DEPTH = 4;
  localparam logic [17:0] HALT_W = {5'd31, 13'd0};

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] start_addr;
  logic          redirect;
  logic [AW-1:0] redirect_addr;
  logic          imem_rd_en;
  logic [AW-1:0] imem_addr;
  logic [17:0]   imem_rdata = '0;
  logic [17:0]   raw_instruction;
  logic          instr_valid;
  logic          instr_ready;
  logic          busy;
  logic          halted;
`ifdef FETCH_PERF_EN
  logic [31:0]   fetch_count;
  logic [31:0]   stall_count;
`endif

  logic [17:0] mem [1024];
  logic [17:0] got [$];
  int checks = 0;
  int errors = 0;

  instr_fetch #(
    .ADDR_W     (AW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .start_addr      (start_addr),
    .redirect        (redirect),
    .redirect_addr   (redirect_addr),
    .imem_rd_en      (imem_rd_en),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .raw_instruction (raw_instruction),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .busy            (busy),
    .halted          (halted)
`ifdef FETCH_PERF_EN
    ,
    .fetch_count     (fetch_count),
    .stall_count     (stall_count)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_rd_en) imem_rdata <= mem[imem_addr];
  end

  function automatic logic [17:0] add_word(input int a);
    return {5'd1, 13'(a)};
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic start_at(input logic [AW-1:0] a);
    start      = 1'b1;
    start_addr = a;
    step();
    start      = 1'b0;
  endtask

  // Gathers every word handed over until halted is seen or the budget runs out.
  task automatic collect(input int budget, output bit done);
    done = 1'b0;
    got.delete();
    for (int c = 0; c < budget; c++) begin
      if (instr_valid && instr_ready) got.push_back(raw_instruction);
      if (halted) begin
        done = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; redirect = 1'b0; instr_ready = 1'b0;
    start_addr = '0; redirect_addr = '0;
    step(); step();
    checks++; if (imem_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b exp 0", imem_rd_en); end
    checks++; if (imem_addr !== '0) begin errors++; $display("FAIL reset_addr: got %h exp 0", imem_addr); end
    checks++; if (raw_instruction !== '0) begin errors++; $display("FAIL reset_raw: got %h exp 0", raw_instruction); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", instr_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b exp 0", halted); end
    reset = 1'b0;
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b exp 0", busy); end
  endtask

  task automatic test_basic();
    instr_ready = 1'b1;
    start_at(10'h000);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b exp 1", busy); end
    checks++; if (imem_rd_en !== 1'b1) begin errors++; $display("FAIL basic_rd_en: got %b exp 1", imem_rd_en); end
    checks++; if (imem_addr !== 10'h000) begin errors++; $display("FAIL basic_addr0: got %h exp 000", imem_addr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_n1: got %b exp 0", instr_valid); end
    step();
    checks++; if (imem_addr !== 10'h001) begin errors++; $display("FAIL basic_addr1: got %h exp 001", imem_addr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_n2: got %b exp 0", instr_valid); end
    step();
    for (int k = 0; k < 4; k++) begin
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL basic_valid_w%0d: got %b exp 1", k, instr_valid); end
      checks++; if (raw_instruction !== add_word(k)) begin errors++; $display("FAIL basic_word%0d: got %h exp %h", k, raw_instruction, add_word(k)); end
      step();
    end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL basic_no_halt_word: got %b exp 0", instr_valid); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_drain_busy: got %b exp 1", busy); end
    checks++; if (imem_rd_en !== 1'b0) begin errors++; $display("FAIL basic_drain_rd_en: got %b exp 0", imem_rd_en); end
    step();
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL basic_halted: got %b exp 1", halted); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_halted_busy: got %b exp 0", busy); end
  endtask

  task automatic test_stall();
    int  reads;
    bit  done;
    instr_ready = 1'b0;
    start_at(10'h000);
    reads = 0;
    for (int c = 0; c < 10; c++) begin
      if (imem_rd_en) reads++;
      step();
    end
    checks++; if (reads != DEPTH) begin errors++; $display("FAIL stall_reads: got %0d exp %0d", reads, DEPTH); end
    checks++; if (imem_rd_en !== 1'b0) begin errors++; $display("FAIL stall_rd_en: got %b exp 0", imem_rd_en); end
    checks++; if (raw_instruction !== add_word(0)) begin errors++; $display("FAIL stall_head: got %h exp %h", raw_instruction, add_word(0)); end
    instr_ready = 1'b1;
    collect(40, done);
    checks++; if (!done) begin errors++; $display("FAIL stall_timeout: halted=%b exp 1", halted); end
    checks++; if (got.size() != 4) begin errors++; $display("FAIL stall_count: got %0d words exp 4", got.size()); end
    for (int i = 0; i < got.size() && i < 4; i++) begin
      checks++; if (got[i] !== add_word(i)) begin errors++; $display("FAIL stall_word%0d: got %h exp %h", i, got[i], add_word(i)); end
    end
  endtask

  task automatic test_redirect();
    bit done;
    instr_ready = 1'b0;
    start_at(10'h000);
    repeat (4) step();
    checks++; if (raw_instruction !== add_word(0)) begin errors++; $display("FAIL redir_pre_head: got %h exp %h", raw_instruction, add_word(0)); end
    redirect = 1'b1; redirect_addr = 10'h010;
    step();
    redirect = 1'b0; instr_ready = 1'b1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_valid_n1: got %b exp 0", instr_valid); end
    checks++; if (imem_rd_en !== 1'b1) begin errors++; $display("FAIL redir_rd_en: got %b exp 1", imem_rd_en); end
    checks++; if (imem_addr !== 10'h010) begin errors++; $display("FAIL redir_addr: got %h exp 010", imem_addr); end
    step();
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_valid_n2: got %b exp 0", instr_valid); end
    step();
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL redir_valid_n3: got %b exp 1", instr_valid); end
    checks++; if (raw_instruction !== add_word(16)) begin errors++; $display("FAIL redir_first: got %h exp %h", raw_instruction, add_word(16)); end
    collect(40, done);
    checks++; if (!done) begin errors++; $display("FAIL redir_timeout: halted=%b exp 1", halted); end
    checks++; if (got.size() != 4) begin errors++; $display("FAIL redir_count: got %0d words exp 4", got.size()); end
    for (int i = 0; i < got.size() && i < 4; i++) begin
      checks++; if (got[i] !== add_word(16 + i)) begin errors++; $display("FAIL redir_word%0d: got %h exp %h", i, got[i], add_word(16 + i)); end
    end
  endtask

  task automatic test_drain_redirect();
    bit done;
    instr_ready = 1'b1;
    start_at(10'h000);
    repeat (6) step();
    checks++; if (busy !== 1'b1 || halted !== 1'b0) begin errors++; $display("FAIL drain_state: got busy=%b halted=%b exp busy=1 halted=0", busy, halted); end
    checks++; if (imem_rd_en !== 1'b0) begin errors++; $display("FAIL drain_rd_en: got %b exp 0", imem_rd_en); end
    redirect = 1'b1; redirect_addr = 10'h000;
    step();
    redirect = 1'b0;
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL drain_redir_halted: got %b exp 0", halted); end
    checks++; if (imem_rd_en !== 1'b1) begin errors++; $display("FAIL drain_redir_rd_en: got %b exp 1", imem_rd_en); end
    checks++; if (imem_addr !== 10'h000) begin errors++; $display("FAIL drain_redir_addr: got %h exp 000", imem_addr); end
    collect(40, done);
    checks++; if (!done) begin errors++; $display("FAIL drain_timeout: halted=%b exp 1", halted); end
    checks++; if (got.size() != 4) begin errors++; $display("FAIL drain_count: got %0d words exp 4", got.size()); end
    for (int i = 0; i < got.size() && i < 4; i++) begin
      checks++; if (got[i] !== add_word(i)) begin errors++; $display("FAIL drain_word%0d: got %h exp %h", i, got[i], add_word(i)); end
    end
  endtask

  task automatic test_wrap();
    bit done;
    mem[1] = HALT_W;
    instr_ready = 1'b1;
    start_at(10'h3FE);
    checks++; if (imem_addr !== 10'h3FE) begin errors++; $display("FAIL wrap_addr0: got %h exp 3fe", imem_addr); end
    step();
    checks++; if (imem_addr !== 10'h3FF) begin errors++; $display("FAIL wrap_addr1: got %h exp 3ff", imem_addr); end
    step();
    checks++; if (imem_addr !== 10'h000) begin errors++; $display("FAIL wrap_addr2: got %h exp 000", imem_addr); end
    collect(40, done);
    checks++; if (!done) begin errors++; $display("FAIL wrap_timeout: halted=%b exp 1", halted); end
    checks++; if (got.size() != 3) begin errors++; $display("FAIL wrap_count: got %0d words exp 3", got.size()); end
    if (got.size() == 3) begin
      checks++; if (got[0] !== add_word(10'h3FE)) begin errors++; $display("FAIL wrap_word0: got %h exp %h", got[0], add_word(10'h3FE)); end
      checks++; if (got[1] !== add_word(10'h3FF)) begin errors++; $display("FAIL wrap_word1: got %h exp %h", got[1], add_word(10'h3FF)); end
      checks++; if (got[2] !== add_word(0)) begin errors++; $display("FAIL wrap_word2: got %h exp %h", got[2], add_word(0)); end
    end
    mem[1] = add_word(1);
  endtask

  task automatic test_reset_mid();
    bit done;
    instr_ready = 1'b0;
    start_at(10'h000);
    repeat (5) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b exp 0", instr_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b exp 0", busy); end
    checks++; if (imem_rd_en !== 1'b0) begin errors++; $display("FAIL rstmid_rd_en: got %b exp 0", imem_rd_en); end
    checks++; if (imem_addr !== 10'h000) begin errors++; $display("FAIL rstmid_addr: got %h exp 000", imem_addr); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rstmid_halted: got %b exp 0", halted); end
    step();
    instr_ready = 1'b1;
    start_at(10'h010);
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid_n1: got %b exp 0", instr_valid); end
    step();
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid_n2: got %b exp 0", instr_valid); end
    step();
    checks++; if (raw_instruction !== add_word(16) || instr_valid !== 1'b1) begin errors++; $display("FAIL rstmid_first: got %h v=%b exp %h v=1", raw_instruction, instr_valid, add_word(16)); end
    collect(40, done);
    checks++; if (!done) begin errors++; $display("FAIL rstmid_timeout: halted=%b exp 1", halted); end
    checks++; if (got.size() != 4) begin errors++; $display("FAIL rstmid_count: got %0d words exp 4", got.size()); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = add_word(i);
    mem[4]     = HALT_W;
    mem[10'h014] = HALT_W;
    test_reset();
    test_basic();
    test_stall();
    test_redirect();
    test_drain_redirect();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
